mul_rndpack: RTL and testbench

- Back end of the floating-point multiplier datapath.
- Consumes the raw significand product, the unbiased exponent sum and the special-case flags from the multiplier front-end classifier.
- Normalizes, rounds to nearest-even, detects overflow/underflow and packs the IEEE-754 result word plus exception flags.
- Two-stage pipeline with valid/ready on both sides; sits between the partial-product multiplier and the FPU writeback.

---
 rtl/mul_pkg.sv | 43 ++++
 rtl/mul_rndpack_lzc.sv | 17 +
 rtl/mul_rndpack.sv | 145 ++++++++++++++
 tb/tb_mul_rndpack.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the floating-point multiplier back end.
// Stage-register types are sized for the single-precision default widths.
package mul_pkg;

  localparam int FP_EXPO_W = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_PW     = 2*FP_MANT_W + 2;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXPO_W-1:0] expo;
    logic [FP_MANT_W-1:0] mant;
  } fp_t;

  typedef struct packed {
    logic                 sign;
    logic                 r_isnan;
    logic                 r_is0nan;
    logic                 is_inf_nan;
    logic                 is_zero;
    logic [FP_EXPO_W+2:0] e1;
    logic [FP_PW-1:0]     norm;
  } s1_t;

  typedef struct packed {
    fp_t        res;
    logic [3:0] flags;
  } s2_t;

  function automatic fp_t qnan(input int ew, input int mw);
    fp_t q;
    q.sign = 1'b0;
    q.expo = FP_EXPO_W'((1 << ew) - 1);
    q.mant = FP_MANT_W'(1) << (mw - 1);
    return q;
  endfunction

endpackage

// File: rtl/mul_rndpack_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module lzc #(
  parameter  int W  = 48,
  localparam int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_vec[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/mul_rndpack.sv
// Multiplier back end: normalize, round-to-nearest-even, detect over/underflow
// and pack the IEEE-754 word in a two-stage valid/ready pipeline.
module mul_rndpack import mul_pkg::*; #(
  parameter  int EXPO_W = FP_EXPO_W,
  parameter  int MANT_W = FP_MANT_W,
  localparam int PW     = 2*MANT_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXPO_W+1:0]        in_expo,
  input  logic [PW-1:0]            in_prod,
  input  logic                     in_a_is_n0,
  input  logic                     in_b_is_n0,
  input  logic                     in_r_isnan,
  input  logic                     in_r_is0nan,
  input  logic                     in_is_inf_nan,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXPO_W+MANT_W:0]   out_res,
  output logic [3:0]               out_flags
);

  localparam int LZW = $clog2(PW+1);
  localparam int EW1 = EXPO_W + 3;
  localparam int WW  = PW + MANT_W + 3;
  localparam int RW  = EXPO_W + 2 + MANT_W;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv;
  logic [LZW-1:0] lz;

  lzc #(.W(PW)) u_lzc (.in_vec(in_prod), .cnt(lz));

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign       = in_sign;
        s1_d.r_isnan    = in_r_isnan;
        s1_d.r_is0nan   = in_r_is0nan;
        s1_d.is_inf_nan = in_is_inf_nan;
        s1_d.is_zero    = !in_a_is_n0 || !in_b_is_n0;
        s1_d.e1         = {in_expo[EXPO_W+1], in_expo} + EW1'(1) - EW1'(lz);
        s1_d.norm       = in_prod << lz;
      end
    end
  end

  logic             tiny, sat, sticky_sat, guard, sticky, inc, ovf, inexact;
  logic [EW1:0]     amt;
  logic [WW-1:0]    wide, shifted;
  logic [MANT_W:0]  kept;
  logic [EXPO_W+1:0] exp_base;
  logic [RW-1:0]    rounded;
  fp_t              res;
  logic [3:0]       flags;

  always_comb begin
    tiny       = s1_q.e1[EW1-1] || (s1_q.e1 == '0);
    amt        = (EW1+1)'(1) - {s1_q.e1[EW1-1], s1_q.e1};
    sat        = amt >= (EW1+1)'(MANT_W + 3);
    wide       = {s1_q.norm, (MANT_W+3)'(0)};
    shifted    = wide;
    sticky_sat = 1'b0;
    if (tiny) begin
      if (sat) begin
        shifted    = '0;
        sticky_sat = |s1_q.norm;
      end else begin
        shifted = wide >> amt;
      end
    end
    kept   = shifted[WW-1 -: MANT_W+1];
    guard  = shifted[WW-MANT_W-2];
    sticky = (|shifted[WW-MANT_W-3:0]) | sticky_sat;
    inc    = guard && (sticky || kept[0]);

    // The hidden bit of kept adds the missing 1 back onto e1-1, and a rounding
    // carry ripples naturally into the exponent field.
    exp_base = tiny ? '0 : s1_q.e1[EXPO_W+1:0] - (EXPO_W+2)'(1);
    rounded  = {exp_base, MANT_W'(0)} + RW'(kept) + RW'(inc);
    ovf      = rounded[RW-1:MANT_W] >= (EXPO_W+2)'((1 << EXPO_W) - 1);
    inexact  = guard || sticky;

    res           = {s1_q.sign, rounded[EXPO_W+MANT_W-1:0]};
    flags         = '0;
    flags[FLG_NX] = inexact || ovf;
    flags[FLG_UF] = tiny && inexact;
    flags[FLG_OF] = ovf;
    if (ovf) res = {s1_q.sign, {EXPO_W{1'b1}}, MANT_W'(0)};

    if (s1_q.r_isnan) begin
      res           = qnan(EXPO_W, MANT_W);
      flags         = '0;
      flags[FLG_NV] = s1_q.r_is0nan;
    end else if (s1_q.is_inf_nan) begin
      res   = {s1_q.sign, {EXPO_W{1'b1}}, MANT_W'(0)};
      flags = '0;
    end else if (s1_q.is_zero) begin
      res   = {s1_q.sign, EXPO_W'(0), MANT_W'(0)};
      flags = '0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = '{res: res, flags: flags};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_q.res;
  assign out_flags = s2_q.flags;

endmodule

// File: tb/tb_mul_rndpack.sv
// Scoreboard bench for mul_rndpack: directed single-precision vectors with
// hand-computed results, back-pressure and mid-flight reset.
module tb_mul_rndpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [9:0]  in_expo;
  logic [47:0] in_prod;
  logic        in_a_is_n0, in_b_is_n0, in_r_isnan, in_r_is0nan, in_is_inf_nan;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   op_id  = 0;

  mul_rndpack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_expo(in_expo), .in_prod(in_prod),
    .in_a_is_n0(in_a_is_n0), .in_b_is_n0(in_b_is_n0),
    .in_r_isnan(in_r_isnan), .in_r_is0nan(in_r_is0nan),
    .in_is_inf_nan(in_is_inf_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // cls = {a_n0, b_n0, r_isnan, r_is0nan, is_inf_nan}
  task automatic applyStimulus(input logic sign, input logic [9:0] expo, input logic [47:0] prod,
                               input logic [4:0] cls, input logic [31:0] e_res,
                               input logic [3:0] e_flags, input bit keep);
    bit done = 0;
    in_sign       = sign;
    in_expo       = expo;
    in_prod       = prod;
    {in_a_is_n0, in_b_is_n0, in_r_isnan, in_r_is0nan, in_is_inf_nan} = cls;
    in_valid      = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (keep) sb_q.push_back('{id: op_id, res: e_res, flags: e_flags});
        op_id++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready low expected accept within 20 cycles");
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %h expected none", out_res);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput($sformatf("res#%0d", mon_e.id), out_res, mon_e.res);
        checkOutput($sformatf("flags#%0d", mon_e.id), {28'd0, out_flags}, {28'd0, mon_e.flags});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_sign = 1'b0;
    in_expo = '0; in_prod = '0;
    {in_a_is_n0, in_b_is_n0, in_r_isnan, in_r_is0nan, in_is_inf_nan} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_res", out_res, 32'd0);
    checkOutput("reset_out_flags", {28'd0, out_flags}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1.5 x 2.0 with exact latency check
    applyStimulus(0, 10'd128, 48'h6000_0000_0000, 5'b11000, 32'h4040_0000, 4'b0000, 1);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("latency_2", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    applyStimulus(0, 10'd0,   48'h0,              5'b01111, 32'h7FC0_0000, 4'b1000, 1);
    applyStimulus(0, 10'd0,   48'h0,              5'b11101, 32'h7FC0_0000, 4'b0000, 1);
    applyStimulus(0, 10'd255, 48'h7FFF_FF80_0000, 5'b11000, 32'h7F80_0000, 4'b0101, 1);
    applyStimulus(1, 10'd255, 48'h7FFF_FF80_0000, 5'b11000, 32'hFF80_0000, 4'b0101, 1);
    applyStimulus(0, 10'd0,   48'h4000_0000_0000, 5'b11000, 32'h0040_0000, 4'b0000, 1);
    applyStimulus(0, 10'd0,   48'h7FFF_FF80_0000, 5'b11000, 32'h0080_0000, 4'b0011, 1);
    applyStimulus(0, 10'd127, 48'h4000_00C0_0000, 5'b11000, 32'h3F80_0002, 4'b0001, 1);
    applyStimulus(0, 10'd127, 48'h4000_0040_0000, 5'b11000, 32'h3F80_0000, 4'b0001, 1);
    applyStimulus(0, 10'd0,   48'h0,              5'b11001, 32'h7F80_0000, 4'b0000, 1);
    applyStimulus(1, 10'd0,   48'h0,              5'b01000, 32'h8000_0000, 4'b0000, 1);
    applyStimulus(0, 10'd127, 48'hFFFF_FFC0_0000, 5'b11000, 32'h4080_0000, 4'b0001, 1);
    applyStimulus(0, 10'h3D8, 48'h4000_0000_0000, 5'b11000, 32'h0000_0000, 4'b0011, 1);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // back-pressure: only two ops fit while the output is blocked
    out_ready = 1'b0;
    applyStimulus(0, 10'd128, 48'h6000_0000_0000, 5'b11000, 32'h4040_0000, 4'b0000, 1);
    applyStimulus(0, 10'd0,   48'h4000_0000_0000, 5'b11000, 32'h0040_0000, 4'b0000, 1);
    @(negedge clk);
    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(0, 10'd127, 48'h4000_00C0_0000, 5'b11000, 32'h3F80_0002, 4'b0001, 1);
    applyStimulus(0, 10'd255, 48'h7FFF_FF80_0000, 5'b11000, 32'h7F80_0000, 4'b0101, 1);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("drain_empty", sb_q.size(), 32'd0);

    // reset with two ops in flight: neither may appear afterwards
    out_ready = 1'b0;
    applyStimulus(0, 10'd128, 48'h6000_0000_0000, 5'b11000, 32'h4040_0000, 4'b0000, 0);
    applyStimulus(0, 10'd127, 48'h4000_0040_0000, 5'b11000, 32'h3F80_0000, 4'b0001, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_flight_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_flight_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("final_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
